// File: rtl/hash_top.sv
// Byte-serial 64-bit iterative hash core: every accepted byte is mixed into an
// 8-byte state over ROUNDS cycles, then a length-derived byte finalizes the digest.
module hash_top #(
  parameter int unsigned ROUNDS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_msg,
  input  logic [7:0] msg_byte,
  input  logic       msg_done,
  input  logic       valid_in,
  output logic [7:0] digest [7:0],
  output logic       digest_ready,
  output logic       load_byte,
  output logic       round_exec_active
);

  typedef enum logic [2:0] {IDLE, WAIT, ROUND, FINAL, DONE} state_t;
  typedef logic [7:0] hstate_t [7:0];

  // IV byte i lives in bits [8*i +: 8].
  localparam logic [63:0] IV64       = 64'hEE2B_C0DA_140F_5534;
  localparam logic [7:0]  LAST_ROUND = 8'(ROUNDS - 1);

  state_t      state, state_nxt;
  hstate_t     h, h_nxt, h_round, digest_nxt;
  logic [7:0]  m, m_nxt, r, r_nxt, len_fold;
  logic [15:0] len, len_nxt;
  logic        ready_nxt, load_nxt, busy_nxt, done_pending, pend_nxt;

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned k);
    return (x << k) | (x >> (8 - k));
  endfunction

  assign len_fold = len[7:0] ^ len[15:8];

  // One round: every byte is updated in parallel from the old state.
  for (genvar g = 0; g < 8; g++) begin : g_round
    logic [7:0] sum;
    assign sum        = (h[g] ^ m) + h[(g + 1) % 8] + r;
    assign h_round[g] = rotl8(sum, (g % 4) + 1);
  end

  // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    h_nxt      = h;
    m_nxt      = m;
    r_nxt      = r;
    len_nxt    = len;
    digest_nxt = digest;
    ready_nxt  = digest_ready;
    load_nxt   = 1'b0;
    busy_nxt   = round_exec_active;
    pend_nxt   = done_pending;

    if (start_msg) begin
      for (int i = 0; i < 8; i++) h_nxt[i] = IV64[8*i +: 8];
      len_nxt    = '0;
      r_nxt      = '0;
      digest_nxt = '{default: '0};
      ready_nxt  = 1'b0;
      pend_nxt   = 1'b0;
      if (msg_done) begin
        state_nxt = FINAL;
        m_nxt     = '0;
        busy_nxt  = 1'b1;
      end else begin
        state_nxt = WAIT;
        busy_nxt  = 1'b0;
      end
    end else begin
      case (state)
        WAIT: begin
          if (valid_in) begin
            m_nxt     = msg_byte;
            len_nxt   = len + 16'd1;
            load_nxt  = 1'b1;
            busy_nxt  = 1'b1;
            r_nxt     = '0;
            pend_nxt  = msg_done;
            state_nxt = ROUND;
          end else if (msg_done) begin
            m_nxt     = len_fold;
            r_nxt     = '0;
            busy_nxt  = 1'b1;
            state_nxt = FINAL;
          end
        end
        ROUND: begin
          h_nxt    = h_round;
          r_nxt    = r + 8'd1;
          pend_nxt = done_pending | msg_done;
          if (r == LAST_ROUND) begin
            r_nxt = '0;
            // A late msg_done on the last round edge still counts.
            if (done_pending || msg_done) begin
              m_nxt     = len_fold;
              pend_nxt  = 1'b0;
              state_nxt = FINAL;
            end else begin
              busy_nxt  = 1'b0;
              state_nxt = WAIT;
            end
          end
        end
        FINAL: begin
          h_nxt = h_round;
          r_nxt = r + 8'd1;
          if (r == LAST_ROUND) begin
            r_nxt      = '0;
            busy_nxt   = 1'b0;
            digest_nxt = h_round;
            ready_nxt  = 1'b1;
            state_nxt  = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the hash state and digest are small register arrays, not RAM, so they are reset explicitly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      h                 <= '{default: '0};
      digest            <= '{default: '0};
      m                 <= '0;
      r                 <= '0;
      len               <= '0;
      digest_ready      <= 1'b0;
      load_byte         <= 1'b0;
      round_exec_active <= 1'b0;
      done_pending      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make all registers update together from pre-edge values.
      state             <= state_nxt;
      h                 <= h_nxt;
      digest            <= digest_nxt;
      m                 <= m_nxt;
      r                 <= r_nxt;
      len               <= len_nxt;
      digest_ready      <= ready_nxt;
      load_byte         <= load_nxt;
      round_exec_active <= busy_nxt;
      done_pending      <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_hash_top.sv
// Self-checking bench for hash_top: directed and random messages compared
// against a byte-level model of the hash algorithm.
module tb_hash_top;

  localparam int unsigned ROUNDS = 4;
  localparam logic [63:0] IV64   = 64'hEE2B_C0DA_140F_5534;

  typedef logic [7:0] hstate_t [8];
  typedef logic [7:0] msg_t [$];

  logic       clk       = 1'b0;
  logic       reset_n   = 1'b0;
  logic       start_msg = 1'b0;
  logic       msg_done  = 1'b0;
  logic       valid_in  = 1'b0;
  logic [7:0] msg_byte  = 8'h00;
  logic [7:0] digest [7:0];
  logic       digest_ready, load_byte, round_exec_active;

  int checks   = 0;
  int failures = 0;
  int load_cnt = 0;

  hash_top #(.ROUNDS(ROUNDS)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start_msg         (start_msg),
    .msg_byte          (msg_byte),
    .msg_done          (msg_done),
    .valid_in          (valid_in),
    .digest            (digest),
    .digest_ready      (digest_ready),
    .load_byte         (load_byte),
    .round_exec_active (round_exec_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (load_byte === 1'b1) load_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: the round rule applied byte by byte on a plain array.
  function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
    logic [15:0] w;
    w = {x, x} << k;
    return w[15:8];
  endfunction

  function automatic hstate_t absorb(input hstate_t h, input logic [7:0] m);
    hstate_t    cur, nxt;
    logic [7:0] t;
    cur = h;
    for (int rr = 0; rr < int'(ROUNDS); rr++) begin
      for (int i = 0; i < 8; i++) begin
        t      = (cur[i] ^ m) + cur[(i + 1) % 8] + 8'(rr);
        nxt[i] = rotl(t, (i % 4) + 1);
      end
      cur = nxt;
    end
    return cur;
  endfunction

  function automatic logic [63:0] golden(input msg_t msg);
    hstate_t     h;
    logic [15:0] len;
    logic [63:0] out;
    for (int i = 0; i < 8; i++) h[i] = IV64[8*i +: 8];
    len = 16'(msg.size());
    foreach (msg[k]) h = absorb(h, msg[k]);
    h = absorb(h, len[7:0] ^ len[15:8]);
    for (int i = 0; i < 8; i++) out[8*i +: 8] = h[i];
    return out;
  endfunction

  function automatic logic [63:0] dut_digest();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = digest[i];
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check(tag, 64'(obs), 64'(exp));
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    check(tag, 64'(obs), 64'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until digest_ready, then verify latency and digest.
  task automatic finish_wait(input string tag, input int exp_ticks, input logic [63:0] exp);
    int k;
    k = 0;
    while (digest_ready !== 1'b1 && k < 300) begin
      tick();
      k++;
    end
    check_int({tag, "_ready_lat"}, k, exp_ticks);
    check_bit({tag, "_busy_off"}, round_exec_active, 1'b0);
    check({tag, "_digest"}, dut_digest(), exp);
  endtask

  // mode 0: msg_done in WAIT; 1: with the last byte; 2: during the last byte's rounds.
  task automatic run_msg(input string tag, input msg_t msg, input int mode);
    logic [63:0] exp;
    int          lb0, n, g;
    bit          last;
    exp = golden(msg);
    lb0 = load_cnt;
    start_msg = 1'b1;
    msg_done  = (msg.size() == 0);
    tick();
    start_msg = 1'b0;
    msg_done  = 1'b0;
    check_bit({tag, "_ready_clr"}, digest_ready, 1'b0);
    check({tag, "_digest_clr"}, dut_digest(), 64'h0);
    if (msg.size() == 0) begin
      finish_wait(tag, ROUNDS, exp);
    end else begin
      foreach (msg[k]) begin
        last     = (k == msg.size() - 1);
        valid_in = 1'b1;
        msg_byte = msg[k];
        msg_done = last && (mode == 1);
        tick();
        msg_done = 1'b0;
        check_bit({tag, "_load"}, load_byte, 1'b1);
        if (last && mode != 0) begin
          tick();
          valid_in = 1'b0;
          check_bit({tag, "_load_pulse"}, load_byte, 1'b0);
          if (mode == 2) begin
            msg_done = 1'b1;
            tick();
            msg_done = 1'b0;
            finish_wait(tag, 2 * ROUNDS - 2, exp);
          end else begin
            finish_wait(tag, 2 * ROUNDS - 1, exp);
          end
        end else begin
          n = 0;
          g = 0;
          while (round_exec_active === 1'b1 && g < 300) begin
            n++;
            tick();
            g++;
            if (g == 1) begin
              valid_in = 1'b0;
              check_bit({tag, "_load_pulse"}, load_byte, 1'b0);
            end
          end
          valid_in = 1'b0;
          check_int({tag, "_busy_len"}, n, ROUNDS);
        end
      end
      if (mode == 0) begin
        msg_done = 1'b1;
        tick();
        msg_done = 1'b0;
        check_bit({tag, "_final_busy"}, round_exec_active, 1'b1);
        finish_wait(tag, ROUNDS, exp);
      end
    end
    check_int({tag, "_loads"}, load_cnt - lb0, msg.size());
  endtask

  initial begin
    msg_t        hello, q, empty_q;
    logic [63:0] exp;
    logic [7:0]  b0, b1;
    int          lb0, n, g, len;

    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64};

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    tick();
    check("rst_digest", dut_digest(), 64'h0);
    check_bit("rst_ready", digest_ready, 1'b0);
    check_bit("rst_load", load_byte, 1'b0);
    check_bit("rst_busy", round_exec_active, 1'b0);

    // valid_in / msg_done are ignored in IDLE
    lb0 = load_cnt;
    valid_in = 1'b1;
    msg_done = 1'b1;
    msg_byte = 8'h5A;
    repeat (3) tick();
    valid_in = 1'b0;
    msg_done = 1'b0;
    check_bit("idle_busy", round_exec_active, 1'b0);
    check_bit("idle_ready", digest_ready, 1'b0);
    check_int("idle_loads", load_cnt - lb0, 0);

    // Directed messages
    run_msg("empty", empty_q, 0);
    run_msg("hello1", hello, 0);
    run_msg("hello2", hello, 0);
    q = '{8'h00};
    run_msg("single0", q, 1);

    // Inputs in DONE leave the digest untouched
    exp = golden(q);
    lb0 = load_cnt;
    valid_in = 1'b1;
    msg_done = 1'b1;
    msg_byte = 8'hA5;
    repeat (3) tick();
    valid_in = 1'b0;
    msg_done = 1'b0;
    check("done_hold_digest", dut_digest(), exp);
    check_bit("done_hold_ready", digest_ready, 1'b1);
    check_int("done_hold_loads", load_cnt - lb0, 0);

    // valid_in held high across the round engine
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    q = '{b0, b1};
    start_msg = 1'b1;
    tick();
    start_msg = 1'b0;
    valid_in  = 1'b1;
    msg_byte  = b0;
    tick();
    check_bit("held_load1", load_byte, 1'b1);
    msg_byte = b1;
    n = 0;
    for (int j = 0; j < int'(ROUNDS); j++) begin
      tick();
      if (load_byte === 1'b1) n++;
    end
    check_int("held_no_load", n, 0);
    check_bit("held_busy_off", round_exec_active, 1'b0);
    tick();
    check_bit("held_load2", load_byte, 1'b1);
    valid_in = 1'b0;
    g = 0;
    while (round_exec_active === 1'b1 && g < 300) begin
      tick();
      g++;
    end
    msg_done = 1'b1;
    tick();
    msg_done = 1'b0;
    finish_wait("held", ROUNDS, golden(q));

    // Random messages and msg_done placements
    for (int t = 0; t < 8; t++) begin
      q.delete();
      len = int'($urandom_range(0, 12));
      for (int k = 0; k < len; k++) q.push_back(8'($urandom));
      run_msg($sformatf("rand%0d", t), q, int'($urandom_range(0, 2)));
    end

    // Asynchronous reset while holding a digest
    #1 reset_n = 1'b0;
    #1;
    check("arst_done_digest", dut_digest(), 64'h0);
    check_bit("arst_done_ready", digest_ready, 1'b0);
    #2 reset_n = 1'b1;

    // Asynchronous reset mid-round
    tick();
    start_msg = 1'b1;
    tick();
    start_msg = 1'b0;
    valid_in  = 1'b1;
    msg_byte  = 8'h11;
    tick();
    valid_in = 1'b0;
    check_bit("arst_pre_busy", round_exec_active, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check_bit("arst_load", load_byte, 1'b0);
    check_bit("arst_busy", round_exec_active, 1'b0);
    check_bit("arst_ready", digest_ready, 1'b0);
    #2 reset_n = 1'b1;
    tick();
    check_bit("arst_idle_busy", round_exec_active, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
